// File: rtl/ahb_slave_mem_if.sv
// AHB slave-side bus bundle between the decoder/master and ahb_slave_mem.
// Clock and reset stay outside the bundle as plain module ports.
interface ahb_slave_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [1:0]            htrans;
   logic [DATA_WIDTH-1:0] hwdata;
   logic                  hreadyin;
   logic                  hready;
   logic                  hresp;
   logic [DATA_WIDTH-1:0] hrdata;

   modport master (
      output hsel, haddr, hwrite, hsize, hburst, htrans, hwdata, hreadyin,
      input  hready, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, hwrite, hsize, hburst, htrans, hwdata, hreadyin,
      output hready, hresp, hrdata
   );
endinterface

// File: rtl/ahb_slave_mem.sv
// Word-organised AHB slave memory: configurable wait states, byte/halfword/word
// lanes (little-endian), two-cycle ERROR response for illegal accesses.
module ahb_slave_mem #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 1
) (
   input logic            hclk,
   input logic            hresetn,
   ahb_slave_mem_if.slave bus
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int LANES = DATA_WIDTH / 8;
   localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  active_q, active_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wr_q;
   logic [2:0]            size_q;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  hready_int;
   logic                  hresp_int;
   logic                  accept;
   logic                  req_illegal;
   logic                  write_commit;
   logic [IDX_W-1:0]      word_idx;
   logic [LANES-1:0]      lane_en;

   function automatic logic is_illegal(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [2:0]            s);
      logic bad;
      bad = ((a >> (IDX_W + 2)) != '0)
          | (s > 3'b010)
          | ((s == 3'b001) & a[0])
          | ((s == 3'b010) & (a[1:0] != 2'b00));
      return bad;
   endfunction

   assign hready_int  = !(state_q == ST_WAIT || state_q == ST_ERR1);
   assign hresp_int   = (state_q == ST_ERR1 || state_q == ST_ERR2);
   assign accept      = bus.hsel & bus.hreadyin & bus.htrans[1] & hready_int;
   // Legality is decoded on the same values that get registered, so the
   // first data-phase cycle already knows whether it is an error phase.
   assign req_illegal = is_illegal(bus.haddr, bus.hsize);

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      unique case (state_q)
         ST_IDLE: active_d = 1'b0;
         ST_WAIT: begin
            if (cnt_q == 3'd0) state_d = ST_IDLE;
            else               cnt_d   = cnt_q - 3'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         ST_ERR2: begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         if (req_illegal) begin
            state_d  = ST_ERR1;
            active_d = 1'b0;
         end else if (WAIT_STATES == 0) begin
            state_d  = ST_IDLE;
            active_d = 1'b1;
         end else begin
            state_d  = ST_WAIT;
            cnt_d    = WS_LOAD;
            active_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd0;
         active_q <= 1'b0;
         addr_q   <= '0;
         wr_q     <= 1'b0;
         size_q   <= 3'b000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         if (accept) begin
            addr_q <= bus.haddr;
            wr_q   <= bus.hwrite;
            size_q <= bus.hsize;
         end
      end
   end

   assign word_idx     = addr_q[IDX_W+1:2];
   assign write_commit = active_q & wr_q & (state_q == ST_IDLE);

   always_comb begin
      lane_en = '0;
      unique case (size_q)
         3'b000:  lane_en = LANES'(1) << addr_q[1:0];
         3'b001:  lane_en = addr_q[1] ? LANES'(4'b1100) : LANES'(4'b0011);
         default: lane_en = {LANES{1'b1}};
      endcase
   end

   // NOTE: the array has no reset branch; contents stay undefined until written.
   always_ff @(posedge hclk) begin
      if (hresetn && write_commit) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) mem[word_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
         end
      end
   end

   assign bus.hready = hready_int;
   assign bus.hresp  = hresp_int;
   assign bus.hrdata = (active_q && !wr_q) ? mem[word_idx] : '0;

   logic unused_bits;
   assign unused_bits = ^{bus.hburst, addr_q[ADDR_WIDTH-1:IDX_W+2]};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances with 0, 1 and 3 wait states
// share one stimulus bus; each transfer selects exactly one of them.
module tb_ahb_slave_mem;

   logic        hclk = 1'b0;
   logic        hresetn = 1'b0;
   logic [2:0]  hsel_v = '0;
   logic [31:0] haddr = '0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = '0;
   logic [2:0]  hburst = '0;
   logic [1:0]  htrans = '0;
   logic [31:0] hwdata = '0;

   logic [2:0]  hready_a, hresp_a;
   logic [31:0] hrdata_a [3];

   int sel = 1;
   int n_checks = 0;
   int n_pass = 0;

   always #5 hclk = ~hclk;

   ahb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
   ahb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
   ahb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

   assign bus0.hsel = hsel_v[0];  assign bus1.hsel = hsel_v[1];  assign bus2.hsel = hsel_v[2];
   assign bus0.haddr = haddr;     assign bus1.haddr = haddr;     assign bus2.haddr = haddr;
   assign bus0.hwrite = hwrite;   assign bus1.hwrite = hwrite;   assign bus2.hwrite = hwrite;
   assign bus0.hsize = hsize;     assign bus1.hsize = hsize;     assign bus2.hsize = hsize;
   assign bus0.hburst = hburst;   assign bus1.hburst = hburst;   assign bus2.hburst = hburst;
   assign bus0.htrans = htrans;   assign bus1.htrans = htrans;   assign bus2.htrans = htrans;
   assign bus0.hwdata = hwdata;   assign bus1.hwdata = hwdata;   assign bus2.hwdata = hwdata;
   assign bus0.hreadyin = bus0.hready;
   assign bus1.hreadyin = bus1.hready;
   assign bus2.hreadyin = bus2.hready;

   assign hready_a = {bus2.hready, bus1.hready, bus0.hready};
   assign hresp_a  = {bus2.hresp, bus1.hresp, bus0.hresp};
   assign hrdata_a[0] = bus0.hrdata;
   assign hrdata_a[1] = bus1.hrdata;
   assign hrdata_a[2] = bus2.hrdata;

   ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0))
      u_ws0 (.hclk(hclk), .hresetn(hresetn), .bus(bus0));
   ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1))
      u_ws1 (.hclk(hclk), .hresetn(hresetn), .bus(bus1));
   ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3))
      u_ws3 (.hclk(hclk), .hresetn(hresetn), .bus(bus2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic cycle();
      @(posedge hclk);
      #1;
   endtask

   task automatic bus_idle();
      hsel_v = '0;
      haddr  = '0;
      hwrite = 1'b0;
      hsize  = 3'b000;
      htrans = 2'b00;
   endtask

   // One non-pipelined transfer on instance `sel`; hsel drops right after accept.
   task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [2:0] size, input logic [31:0] wdata,
                       input int exp_waits, input logic exp_resp,
                       input logic chk_rd, input logic [31:0] exp_rd);
      int waits = 0;
      hsel_v = 3'b001 << sel;
      haddr  = addr;
      hwrite = wr;
      hsize  = size;
      htrans = 2'b10;
      cycle();
      bus_idle();
      hwdata = wdata;
      while (hready_a[sel] !== 1'b1 && waits < 12) begin
         check({tag, " resp_wait"}, 32'(hresp_a[sel]), 32'(exp_resp));
         waits++;
         cycle();
      end
      check({tag, " waits"}, 32'(waits), 32'(exp_waits));
      check({tag, " resp_done"}, 32'(hresp_a[sel]), 32'(exp_resp));
      if (chk_rd) check({tag, " rdata"}, hrdata_a[sel], exp_rd);
      cycle();
      hwdata = '0;
   endtask

   initial begin
      // Reset with random bus activity: all instances must show reset outputs.
      hresetn = 1'b0;
      for (int c = 0; c < 3; c++) begin
         hsel_v = 3'($urandom);
         haddr  = $urandom;
         hwrite = 1'($urandom);
         hsize  = 3'($urandom);
         hburst = 3'($urandom);
         htrans = 2'($urandom);
         hwdata = $urandom;
         cycle();
         for (int d = 0; d < 3; d++) begin
            check($sformatf("rst c%0d d%0d hready", c, d), 32'(hready_a[d]), 32'd1);
            check($sformatf("rst c%0d d%0d hresp", c, d), 32'(hresp_a[d]), 32'd0);
            check($sformatf("rst c%0d d%0d hrdata", c, d), hrdata_a[d], 32'd0);
         end
      end
      bus_idle();
      hburst = 3'b000;
      hwdata = '0;
      hresetn = 1'b1;
      cycle();

      // Single wait state: word write then read back.
      sel = 1;
      check("idle hready", 32'(hready_a[1]), 32'd1);
      check("idle hrdata", hrdata_a[1], 32'd0);
      xfer("wr10", 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, 1, 1'b0, 1'b0, '0);
      xfer("rd10", 32'h10, 1'b0, 3'b010, '0, 1, 1'b0, 1'b1, 32'hDEADBEEF);

      // Byte and halfword lanes; unused lanes carry junk that must be ignored.
      xfer("wr20", 32'h20, 1'b1, 3'b010, 32'h00000000, 1, 1'b0, 1'b0, '0);
      xfer("wb21", 32'h21, 1'b1, 3'b000, 32'h5A5AAB5A, 1, 1'b0, 1'b0, '0);
      xfer("wh22", 32'h22, 1'b1, 3'b001, 32'h1234C3C3, 1, 1'b0, 1'b0, '0);
      xfer("rd20", 32'h20, 1'b0, 3'b010, '0, 1, 1'b0, 1'b1, 32'h1234AB00);
      xfer("wb23", 32'h23, 1'b1, 3'b000, 32'h99000000, 1, 1'b0, 1'b0, '0);
      xfer("rd20b", 32'h20, 1'b0, 3'b010, '0, 1, 1'b0, 1'b1, 32'h9934AB00);

      // Errors: two-cycle ERROR response, memory untouched.
      xfer("wr04", 32'h04, 1'b1, 3'b010, 32'hCAFEF00D, 1, 1'b0, 1'b0, '0);
      xfer("err06", 32'h06, 1'b1, 3'b010, 32'hFFFFFFFF, 1, 1'b1, 1'b1, 32'h0);
      xfer("rd04", 32'h04, 1'b0, 3'b010, '0, 1, 1'b0, 1'b1, 32'hCAFEF00D);
      xfer("wr00", 32'h00, 1'b1, 3'b010, 32'h11111111, 1, 1'b0, 1'b0, '0);
      xfer("err400", 32'h400, 1'b1, 3'b010, 32'hEEEEEEEE, 1, 1'b1, 1'b1, 32'h0);
      xfer("rd00", 32'h00, 1'b0, 3'b010, '0, 1, 1'b0, 1'b1, 32'h11111111);
      xfer("errsz", 32'h10, 1'b1, 3'b011, 32'h0BADBAD0, 1, 1'b1, 1'b1, 32'h0);
      xfer("rd10b", 32'h10, 1'b0, 3'b010, '0, 1, 1'b0, 1'b1, 32'hDEADBEEF);
      xfer("errhw", 32'h11, 1'b0, 3'b001, '0, 1, 1'b1, 1'b1, 32'h0);
      xfer("rd3fc", 32'h3FC, 1'b1, 3'b010, 32'h600DF00D, 1, 1'b0, 1'b0, '0);
      xfer("rd3fcb", 32'h3FC, 1'b0, 3'b010, '0, 1, 1'b0, 1'b1, 32'h600DF00D);

      // Zero wait states, fully pipelined write/write/read/read.
      sel = 0;
      hburst = 3'b001;
      hsel_v = 3'b001; haddr = 32'h0; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
      cycle();
      check("pipe c1 hready", 32'(hready_a[0]), 32'd1);
      check("pipe c1 hresp", 32'(hresp_a[0]), 32'd0);
      hwdata = 32'h5; haddr = 32'h4; htrans = 2'b11;
      cycle();
      check("pipe c2 hready", 32'(hready_a[0]), 32'd1);
      hwdata = 32'h6; haddr = 32'h0; hwrite = 1'b0; htrans = 2'b10;
      cycle();
      check("pipe c3 hready", 32'(hready_a[0]), 32'd1);
      check("pipe rd0", hrdata_a[0], 32'h5);
      hwdata = '0; haddr = 32'h4; htrans = 2'b11;
      cycle();
      check("pipe c4 hready", 32'(hready_a[0]), 32'd1);
      check("pipe rd4", hrdata_a[0], 32'h6);
      bus_idle();
      hburst = 3'b000;
      cycle();
      check("pipe idle hready", 32'(hready_a[0]), 32'd1);
      check("pipe idle hrdata", hrdata_a[0], 32'h0);

      // Three wait states, reset in the second wait cycle discards the write.
      sel = 2;
      xfer("ws3 wr08", 32'h08, 1'b1, 3'b010, 32'h0BADC0DE, 3, 1'b0, 1'b0, '0);
      hsel_v = 3'b100; haddr = 32'h08; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
      cycle();
      bus_idle();
      hwdata = 32'h77;
      check("mid wait1 hready", 32'(hready_a[2]), 32'd0);
      cycle();
      check("mid wait2 hready", 32'(hready_a[2]), 32'd0);
      hresetn = 1'b0;
      cycle();
      check("mid rst hready", 32'(hready_a[2]), 32'd1);
      check("mid rst hresp", 32'(hresp_a[2]), 32'd0);
      check("mid rst hrdata", hrdata_a[2], 32'd0);
      hresetn = 1'b1;
      hwdata = '0;
      cycle();
      xfer("ws3 rd08", 32'h08, 1'b0, 3'b010, '0, 3, 1'b0, 1'b1, 32'h0BADC0DE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
